// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4-to-register-bus bridge.
// Contents: burst and response codes, bridge FSM state and grant encodings.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_CAPT,
      ST_RD_RESP
   } state_t;

   typedef enum logic {
      GNT_READ,
      GNT_WRITE
   } grant_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address generator for AXI bursts, confined to the current 4 KiB page.
// Ports: addr/size/burst in, next_addr out (combinational).
import axi_pkg::*;

module axi_burst_addr #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [2:0]            size,
   input  logic [1:0]            burst,
   output logic [ADDR_WIDTH-1:0] next_addr
);

   logic [1:0]  sz;
   logic [11:0] step;
   logic [11:0] low;

   always_comb begin
      // Data bus is 64 bits, so a beat never moves more than 8 bytes.
      sz   = (size > 3'd3) ? 2'd3 : size[1:0];
      step = 12'd1 << sz;
      low  = addr[11:0] + step;
      unique case (burst)
         // WRAP is handled as INCR; reserved 2'b11 as FIXED.
         BURST_INCR,
         BURST_WRAP: next_addr = {addr[ADDR_WIDTH-1:12], low};
         default:    next_addr = addr;
      endcase
   end

endmodule

// File: rtl/axi_reg_bridge.sv
// AXI4 slave to single-cycle register-bus bridge: one register access per beat,
// FIXED/INCR bursts, fair read/write arbitration, one transaction at a time.
// Ports: clk, rst (sync, active high); AXI4 AW/W/B/AR/R slave channels;
// register bus o_reg_we/o_reg_re/o_reg_addr/o_reg_be/o_reg_wdata, i_reg_rdata
// (registered by target, valid the cycle after o_reg_re).
import axi_pkg::*;

module axi_reg_bridge #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_WIDTH-1:0]   i_awid,
   input  logic [ADDR_WIDTH-1:0] i_awaddr,
   input  logic [7:0]            i_awlen,
   input  logic [2:0]            i_awsize,
   input  logic [1:0]            i_awburst,
   input  logic                  i_awvalid,
   output logic                  o_awready,
   input  logic [63:0]           i_wdata,
   input  logic [7:0]            i_wstrb,
   input  logic                  i_wlast,
   input  logic                  i_wvalid,
   output logic                  o_wready,
   output logic [ID_WIDTH-1:0]   o_bid,
   output logic [1:0]            o_bresp,
   output logic                  o_bvalid,
   input  logic                  i_bready,
   input  logic [ID_WIDTH-1:0]   i_arid,
   input  logic [ADDR_WIDTH-1:0] i_araddr,
   input  logic [7:0]            i_arlen,
   input  logic [2:0]            i_arsize,
   input  logic [1:0]            i_arburst,
   input  logic                  i_arvalid,
   output logic                  o_arready,
   output logic [ID_WIDTH-1:0]   o_rid,
   output logic [63:0]           o_rdata,
   output logic [1:0]            o_rresp,
   output logic                  o_rlast,
   output logic                  o_rvalid,
   input  logic                  i_rready,
   output logic                  o_reg_we,
   output logic                  o_reg_re,
   output logic [ADDR_WIDTH-1:0] o_reg_addr,
   output logic [7:0]            o_reg_be,
   output logic [63:0]           o_reg_wdata,
   input  logic [63:0]           i_reg_rdata
);

   state_t                state_q;
   grant_t                last_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [7:0]            cnt_q;
   logic                  err_q;
   logic [63:0]           rdata_q;

   logic idle;
   logic aw_gnt;
   logic ar_gnt;
   logic last_beat;
   logic wr_data;
   logic rd_addr;

   axi_burst_addr #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_burst_addr (
      .addr      (addr_q),
      .size      (size_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

   assign idle      = (state_q == ST_IDLE);
   assign wr_data   = (state_q == ST_WR_DATA);
   assign rd_addr   = (state_q == ST_RD_ADDR);
   assign last_beat = (cnt_q == len_q);

   // On a tie the side that did not win last time is served.
   assign aw_gnt = idle & i_awvalid
                 & (~i_arvalid | (last_q == GNT_READ));
   assign ar_gnt = idle & i_arvalid
                 & (~i_awvalid | (last_q == GNT_WRITE));

   assign o_awready = aw_gnt;
   assign o_arready = ar_gnt;

   assign o_wready    = wr_data;
   assign o_reg_we    = wr_data & i_wvalid;
   assign o_reg_re    = rd_addr;
   assign o_reg_addr  = addr_q;
   assign o_reg_be    = wr_data ? i_wstrb :
                        rd_addr ? 8'hFF   : 8'h00;
   assign o_reg_wdata = wr_data ? i_wdata : 64'd0;

   assign o_bvalid = (state_q == ST_WR_RESP);
   assign o_bid    = id_q;
   assign o_bresp  = (o_bvalid & err_q) ? RESP_SLVERR : RESP_OKAY;

   assign o_rvalid = (state_q == ST_RD_RESP);
   assign o_rid    = id_q;
   assign o_rdata  = rdata_q;
   assign o_rresp  = RESP_OKAY;
   assign o_rlast  = o_rvalid & last_beat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= GNT_READ;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (aw_gnt) begin
                  id_q    <= i_awid;
                  addr_q  <= i_awaddr;
                  len_q   <= i_awlen;
                  size_q  <= i_awsize;
                  burst_q <= i_awburst;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  last_q  <= GNT_WRITE;
                  state_q <= ST_WR_DATA;
               end else if (ar_gnt) begin
                  id_q    <= i_arid;
                  addr_q  <= i_araddr;
                  len_q   <= i_arlen;
                  size_q  <= i_arsize;
                  burst_q <= i_arburst;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  last_q  <= GNT_READ;
                  state_q <= ST_RD_ADDR;
               end
            end
            ST_WR_DATA: begin
               if (i_wvalid) begin
                  // Beat count comes from awlen; a misplaced wlast only flags an error.
                  if (i_wlast != last_beat) err_q <= 1'b1;
                  addr_q <= next_addr;
                  if (last_beat) state_q <= ST_WR_RESP;
                  else           cnt_q   <= cnt_q + 8'd1;
               end
            end
            ST_WR_RESP: begin
               if (i_bready) state_q <= ST_IDLE;
            end
            ST_RD_ADDR: begin
               state_q <= ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
               rdata_q <= i_reg_rdata;
               state_q <= ST_RD_RESP;
            end
            ST_RD_RESP: begin
               if (i_rready) begin
                  if (last_beat) begin
                     state_q <= ST_IDLE;
                  end else begin
                     cnt_q   <= cnt_q + 8'd1;
                     addr_q  <= next_addr;
                     state_q <= ST_RD_ADDR;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_reg_bridge.sv
// Self-checking bench for axi_reg_bridge: vector table, directed corner
// sequences and randomized transactions against a behavioural model.
module tb_axi_reg_bridge;

   localparam int IDW = 4;
   localparam int AW  = 32;

   logic           clk;
   logic           rst;
   logic [IDW-1:0] awid, arid, bid, rid;
   logic [AW-1:0]  awaddr, araddr, reg_addr;
   logic [7:0]     awlen, arlen, wstrb, reg_be;
   logic [2:0]     awsize, arsize;
   logic [1:0]     awburst, arburst, bresp, rresp;
   logic           awvalid, awready, wlast, wvalid, wready;
   logic           bvalid, bready, arvalid, arready;
   logic           rlast, rvalid, rready, reg_we, reg_re;
   logic [63:0]    wdata, rdata, reg_wdata, reg_rdata;

   int vecs = 0;
   int errs = 0;

   axi_reg_bridge #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen),
      .i_awsize(awsize), .i_awburst(awburst),
      .i_awvalid(awvalid), .o_awready(awready),
      .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast),
      .i_wvalid(wvalid), .o_wready(wready),
      .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid),
      .i_bready(bready),
      .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen),
      .i_arsize(arsize), .i_arburst(arburst),
      .i_arvalid(arvalid), .o_arready(arready),
      .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp),
      .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready),
      .o_reg_we(reg_we), .o_reg_re(reg_re),
      .o_reg_addr(reg_addr), .o_reg_be(reg_be),
      .o_reg_wdata(reg_wdata), .i_reg_rdata(reg_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] tgt_val(input logic [31:0] a);
      return {a ^ 32'h5A5A_0000, ~a};
   endfunction

   // Register target: read data registered, valid the cycle after reg_re.
   always @(posedge clk)
      reg_rdata <= reg_re ? tgt_val(reg_addr) : 64'hDEAD_BEEF_0BAD_F00D;

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk)
      if (!rst) chk("we_re_excl", 256'(reg_we & reg_re), 256'd0);

   // Model: beat-to-beat address from the burst rules.
   function automatic logic [31:0] m_next(input logic [31:0] a,
         input logic [2:0] size, input logic [1:0] burst);
      int unsigned step;
      step = 1 << ((size > 3) ? 3 : size);
      if (burst == 2'd1 || burst == 2'd2)
         return (a & 32'hFFFF_F000) | ((a + step) % 4096);
      return a;
   endfunction

   function automatic logic [255:0] all_outs();
      return {awready, arready, wready, bvalid, bid, bresp,
              rvalid, rid, rdata, rresp, rlast,
              reg_we, reg_re, reg_addr, reg_be, reg_wdata};
   endfunction

   typedef struct {
      bit          wr;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          bad;
      logic [63:0] data;
      logic [7:0]  strb;
      logic [1:0]  resp;
   } vec_t;

   vec_t tbl[12];

   task automatic aw_phase(input vec_t v);
      awid = v.id; awaddr = v.addr; awlen = v.len;
      awsize = v.size; awburst = v.burst; awvalid = 1'b1;
      #1 chk("awready", 256'(awready), 256'd1);
      @(negedge clk);
      awvalid = 1'b0;
   endtask

   task automatic ar_phase(input vec_t v);
      arid = v.id; araddr = v.addr; arlen = v.len;
      arsize = v.size; arburst = v.burst; arvalid = 1'b1;
      #1 chk("arready", 256'(arready), 256'd1);
      @(negedge clk);
      arvalid = 1'b0;
   endtask

   task automatic w_phase(input vec_t v);
      logic [31:0] a;
      a = v.addr;
      for (int b = 0; b <= int'(v.len); b++) begin
         if ($urandom_range(0, 3) == 0) begin
            wvalid = 1'b0;
            #1 chk("w_gap", {wready, reg_we}, 256'b10);
            @(negedge clk);
         end
         wvalid = 1'b1;
         wdata  = v.data + 64'(b);
         wstrb  = v.strb;
         wlast  = (b == int'(v.len)) ^ (b == v.bad);
         #1 chk("wr_beat",
                {wready, reg_we, reg_re, reg_addr, reg_be, reg_wdata},
                {1'b1, 1'b1, 1'b0, a, v.strb, 64'(v.data + 64'(b))});
         @(negedge clk);
         a = m_next(a, v.size, v.burst);
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic b_phase(input logic [3:0] id, input logic [1:0] resp);
      int k;
      #1 chk("bresp", {bvalid, wready, bid, bresp}, {1'b1, 1'b0, id, resp});
      k = $urandom_range(0, 2);
      repeat (k) begin
         @(negedge clk);
         #1 chk("b_hold", {bvalid, bid, bresp}, {1'b1, id, resp});
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      #1 chk("b_done", 256'(bvalid), 256'd0);
   endtask

   task automatic r_phase(input vec_t v);
      logic [31:0]  a;
      logic [255:0] exp;
      int k;
      a = v.addr;
      for (int b = 0; b <= int'(v.len); b++) begin
         #1 chk("rd_addr", {reg_re, reg_we, reg_addr, reg_be, rvalid},
                {1'b1, 1'b0, a, 8'hFF, 1'b0});
         @(negedge clk);
         #1 chk("rd_capt", {reg_re, rvalid}, 256'd0);
         @(negedge clk);
         exp = {1'b1, v.id, tgt_val(a), 2'b00, 1'(b == int'(v.len))};
         #1 chk("rd_resp", {rvalid, rid, rdata, rresp, rlast}, exp);
         k = (b == 0) ? 1 : $urandom_range(0, 2);
         repeat (k) begin
            @(negedge clk);
            #1 chk("r_hold", {rvalid, rid, rdata, rresp, rlast}, exp);
         end
         rready = 1'b1;
         @(negedge clk);
         rready = 1'b0;
         a = m_next(a, v.size, v.burst);
      end
      #1 chk("r_done", {rvalid, reg_re}, 256'd0);
   endtask

   task automatic do_txn(input vec_t v);
      if (v.wr) begin
         aw_phase(v);
         w_phase(v);
         b_phase(v.id, v.resp);
      end else begin
         ar_phase(v);
         r_phase(v);
      end
   endtask

   initial begin
      vec_t v, w1, r1, w2, r2;
      rst = 1'b1;
      {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
      {wdata, wstrb, wlast, wvalid, bready} = '0;
      {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;

      //         wr  id     addr             len     sz    burst bad data        strb   resp
      tbl[0]  = '{1, 4'd5, 32'h0000_0010, 8'd0,   3'd3, 2'd1, -1, 64'd1,      8'h01, 2'b00};
      tbl[1]  = '{0, 4'd3, 32'h0000_0018, 8'd3,   3'd3, 2'd1, -1, 64'd0,      8'h00, 2'b00};
      tbl[2]  = '{1, 4'd9, 32'h0000_0040, 8'd2,   3'd3, 2'd1,  1, 64'hA0,     8'hFF, 2'b10};
      tbl[3]  = '{1, 4'd2, 32'h0000_0080, 8'd2,   3'd2, 2'd0, -1, 64'hB0,     8'h0F, 2'b00};
      tbl[4]  = '{0, 4'd7, 32'h0000_0FF8, 8'd3,   3'd3, 2'd1, -1, 64'd0,      8'h00, 2'b00};
      tbl[5]  = '{1, 4'd6, 32'h1234_5FF8, 8'd3,   3'd3, 2'd1, -1, 64'hC0,     8'hF0, 2'b00};
      tbl[6]  = '{0, 4'd1, 32'h0000_0100, 8'd2,   3'd7, 2'd1, -1, 64'd0,      8'h00, 2'b00};
      tbl[7]  = '{1, 4'd4, 32'h0000_0200, 8'd2,   3'd3, 2'd3, -1, 64'hD0,     8'h3C, 2'b00};
      tbl[8]  = '{0, 4'd8, 32'h0000_0300, 8'd1,   3'd2, 2'd2, -1, 64'd0,      8'h00, 2'b00};
      tbl[9]  = '{1, 4'hF, 32'h0000_0400, 8'd0,   3'd3, 2'd1,  0, 64'hE0,     8'h80, 2'b10};
      tbl[10] = '{1, 4'hA, 32'hABCD_EF80, 8'd255, 3'd0, 2'd1, -1, 64'h1000,   8'h01, 2'b00};
      tbl[11] = '{0, 4'hB, 32'h0000_0800, 8'd255, 3'd3, 2'd1, -1, 64'd0,      8'h00, 2'b00};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("reset_outs", all_outs(), 256'd0);
      @(negedge clk);

      // Simultaneous AW/AR from reset: write first, then alternate.
      w1 = '{1, 4'd1, 32'h500, 8'd1, 3'd3, 2'd1, -1, 64'h55, 8'hAA, 2'b00};
      r1 = '{0, 4'd2, 32'h600, 8'd1, 3'd3, 2'd1, -1, 64'd0,  8'h00, 2'b00};
      w2 = '{1, 4'd3, 32'h700, 8'd0, 3'd3, 2'd1, -1, 64'h77, 8'h11, 2'b00};
      r2 = '{0, 4'd4, 32'h800, 8'd0, 3'd3, 2'd0, -1, 64'd0,  8'h00, 2'b00};
      awid = w1.id; awaddr = w1.addr; awlen = w1.len;
      awsize = w1.size; awburst = w1.burst; awvalid = 1'b1;
      arid = r1.id; araddr = r1.addr; arlen = r1.len;
      arsize = r1.size; arburst = r1.burst; arvalid = 1'b1;
      #1 chk("arb_1_write", {awready, arready}, 256'b10);
      @(negedge clk);
      awvalid = 1'b0;
      #1 chk("arb_busy", {awready, arready}, 256'b00);
      w_phase(w1);
      b_phase(w1.id, w1.resp);
      awid = w2.id; awaddr = w2.addr; awlen = w2.len;
      awsize = w2.size; awburst = w2.burst; awvalid = 1'b1;
      #1 chk("arb_2_read", {awready, arready}, 256'b01);
      @(negedge clk);
      arvalid = 1'b0;
      r_phase(r1);
      arid = r2.id; araddr = r2.addr; arlen = r2.len;
      arsize = r2.size; arburst = r2.burst; arvalid = 1'b1;
      #1 chk("arb_3_write", {awready, arready}, 256'b10);
      @(negedge clk);
      awvalid = 1'b0;
      w_phase(w2);
      b_phase(w2.id, w2.resp);
      #1 chk("arb_4_read", {awready, arready}, 256'b01);
      @(negedge clk);
      arvalid = 1'b0;
      r_phase(r2);
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         do_txn(tbl[i]);
         @(negedge clk);
      end

      // Reset in the middle of a write burst.
      v = '{1, 4'd6, 32'h900, 8'd7, 3'd3, 2'd1, -1, 64'h99, 8'hFF, 2'b00};
      aw_phase(v);
      for (int b = 0; b < 3; b++) begin
         wvalid = 1'b1; wdata = 64'(b); wstrb = 8'hFF; wlast = 1'b0;
         #1 chk("pre_rst_we", 256'(reg_we), 256'd1);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      #1 chk("mid_rst_outs", all_outs(), 256'd0);
      rst = 1'b0;
      wvalid = 1'b0;
      @(negedge clk);
      #1 chk("post_rst_outs", all_outs(), 256'd0);
      v = '{1, 4'd2, 32'hA00, 8'd1, 3'd3, 2'd1, -1, 64'h42, 8'h0F, 2'b00};
      do_txn(v);
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         v.wr    = 1'($urandom_range(0, 1));
         v.id    = 4'($urandom);
         v.addr  = $urandom;
         v.len   = 8'($urandom_range(0, 7));
         v.size  = 3'($urandom);
         v.burst = 2'($urandom);
         v.bad   = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(0, int'(v.len))) : -1;
         v.data  = {$urandom, $urandom};
         v.strb  = 8'($urandom);
         v.resp  = (v.bad >= 0) ? 2'b10 : 2'b00;
         do_txn(v);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
